irrigation_zone_scheduler: RTL and testbench

- Multi-zone, clocked successor to the single-zone combinational irrigation controller.
- Debounces the tank level sensors, latches level-sensor faults, and drives the tank supply valve with fill hysteresis.
- Grants water to one dry zone at a time, round-robin, with bounded run time. Chooses sprinkler or dripper per grant from air and temperature conditions and from tank level.

---
 rtl/irrigation_zone_scheduler.sv | 194 +++++++++++++++++++
 tb/tb_irrigation_zone_scheduler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/irrigation_zone_scheduler.sv
// rtl/irrigation_zone_scheduler.sv - multi-zone irrigation scheduler with level debounce, fault latch and tank fill
module irrigation_zone_scheduler #(
   parameter int N_ZONES         = 4,
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int MIN_ON_CYCLES   = 64,
   parameter int MAX_ON_CYCLES   = 1024,
   parameter int GAP_CYCLES      = 8,
   parameter int CNT_W           = 11
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               low_water_level,
   input  logic               mid_water_level,
   input  logic               high_water_level,
   input  logic [N_ZONES-1:0] earth_humidity,
   input  logic               air_humidity,
   input  logic               low_temperature,
   input  logic               alarm_clear,
   output logic               water_supply_valvule,
   output logic               alarm,
   output logic [N_ZONES-1:0] splinker_bomb,
   output logic [N_ZONES-1:0] dripper_valvule,
   output logic [3:0]         active_zone
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int ZI_W = $clog2(N_ZONES);

   typedef enum logic [1:0] {IDLE, GRANT, RUN, GAP} state_t;

   // bit 0 = low mark, bit 1 = mid mark, bit 2 = high mark
   logic [2:0]         lvl_raw;
   logic [2:0]         lvl_db;
   logic [DB_W-1:0]    db_cnt [3];
   logic [N_ZONES-1:0] eh_s1;
   logic [N_ZONES-1:0] eh_s2;
   logic [N_ZONES-1:0] req;
   logic               fault;
   logic               alarm_rise;
   logic               valve_q;

   state_t             state, state_n;
   logic [ZI_W-1:0]    ptr, ptr_n;
   logic [ZI_W-1:0]    zone, zone_n;
   logic               drip, drip_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic               pick_found;
   logic [ZI_W-1:0]    pick_zone;
   logic [ZI_W-1:0]    cand;
   logic               run_on;
   logic [N_ZONES-1:0] zone_bit;

   assign lvl_raw    = {high_water_level, mid_water_level, low_water_level};
   assign req        = ~eh_s2;
   assign fault      = (lvl_db[2] & ~lvl_db[1]) | (lvl_db[1] & ~lvl_db[0]);
   assign alarm_rise = fault & ~alarm;

   function automatic logic [ZI_W-1:0] next_zone(input logic [ZI_W-1:0] z);
      return (z == ZI_W'(N_ZONES - 1)) ? '0 : z + 1'b1;
   endfunction

   // Per-level debounce: accept a new value once it differs from the accepted one for DEBOUNCE_CYCLES cycles
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lvl_db <= '0;
         for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
      end else begin
         for (int i = 0; i < 3; i++) begin
            if (lvl_raw[i] == lvl_db[i]) begin
               db_cnt[i] <= '0;
            end else if (db_cnt[i] == DB_W'(DEBOUNCE_CYCLES - 1)) begin
               lvl_db[i] <= lvl_raw[i];
               db_cnt[i] <= '0;
            end else begin
               db_cnt[i] <= db_cnt[i] + 1'b1;
            end
         end
      end
   end

   // Two-flop synchroniser for the soil wetness flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eh_s1 <= '0;
         eh_s2 <= '0;
      end else begin
         eh_s1 <= earth_humidity;
         eh_s2 <= eh_s1;
      end
   end

   // Fault latch: sets on any inconsistent level combination, clears only on request once the fault is gone
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) alarm <= 1'b0;
      else if (fault) alarm <= 1'b1;
      else if (alarm_clear) alarm <= 1'b0;
   end

   // Tank fill valve with low/high hysteresis; dropped and re-armed from closed while a fault is latched
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) valve_q <= 1'b0;
      else if (alarm) valve_q <= 1'b0;
      else if (!lvl_db[0]) valve_q <= 1'b1;
      else if (lvl_db[2]) valve_q <= 1'b0;
   end

   assign water_supply_valvule = valve_q & ~alarm;

   // Round-robin pick: first requesting zone at or after the pointer
   always_comb begin
      pick_found = 1'b0;
      pick_zone  = '0;
      cand       = '0;
      for (int k = 0; k < N_ZONES; k++) begin
         cand = (int'(ptr) + k >= N_ZONES) ? ZI_W'(int'(ptr) + k - N_ZONES) : ZI_W'(int'(ptr) + k);
         if (!pick_found && req[cand]) begin
            pick_found = 1'b1;
            pick_zone  = cand;
         end
      end
   end

   // Scheduler state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ptr   <= '0;
         zone  <= '0;
         drip  <= 1'b0;
         cnt   <= '0;
      end else begin
         state <= state_n;
         ptr   <= ptr_n;
         zone  <= zone_n;
         drip  <= drip_n;
         cnt   <= cnt_n;
      end
   end

   // Scheduler next state: grant, bounded run, dead-time gap; a new fault aborts to the gap
   always_comb begin
      state_n = state;
      ptr_n   = ptr;
      zone_n  = zone;
      drip_n  = drip;
      cnt_n   = cnt;
      case (state)
         IDLE: begin
            if (!alarm && lvl_db[0] && (|req)) state_n = GRANT;
         end
         GRANT: begin
            if (pick_found && lvl_db[0]) begin
               zone_n  = pick_zone;
               drip_n  = air_humidity | low_temperature | ~lvl_db[1];
               cnt_n   = '0;
               state_n = RUN;
            end else begin
               state_n = IDLE;
            end
         end
         RUN: begin
            if (!lvl_db[0] || cnt == CNT_W'(MAX_ON_CYCLES - 1) ||
                (cnt >= CNT_W'(MIN_ON_CYCLES - 1) && eh_s2[zone])) begin
               ptr_n   = next_zone(zone);
               cnt_n   = '0;
               state_n = GAP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         GAP: begin
            if (cnt == CNT_W'(GAP_CYCLES - 1)) begin
               cnt_n   = '0;
               state_n = IDLE;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
      if (alarm_rise) begin
         if (state == RUN) ptr_n = next_zone(zone);
         cnt_n   = '0;
         state_n = GAP;
      end
   end

   assign run_on          = (state == RUN);
   assign zone_bit        = {{(N_ZONES-1){1'b0}}, 1'b1} << zone;
   assign splinker_bomb   = (run_on && !drip) ? zone_bit : '0;
   assign dripper_valvule = (run_on && drip)  ? zone_bit : '0;
   assign active_zone     = run_on ? 4'(zone) : 4'd0;

endmodule

// File: tb/tb_irrigation_zone_scheduler.sv
// tb/tb_irrigation_zone_scheduler.sv - scoreboard bench for irrigation_zone_scheduler
module tb_irrigation_zone_scheduler;

   localparam int N       = 4;
   localparam int DEB     = 16;
   localparam int MIN_ON  = 64;
   localparam int MAX_ON  = 1024;
   localparam int GAP     = 8;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         low_water_level = 1'b0;
   logic         mid_water_level = 1'b0;
   logic         high_water_level = 1'b0;
   logic [N-1:0] earth_humidity = '1;
   logic         air_humidity = 1'b0;
   logic         low_temperature = 1'b0;
   logic         alarm_clear = 1'b0;
   logic         water_supply_valvule;
   logic         alarm;
   logic [N-1:0] splinker_bomb;
   logic [N-1:0] dripper_valvule;
   logic [3:0]   active_zone;

   irrigation_zone_scheduler #(
      .N_ZONES(N), .DEBOUNCE_CYCLES(DEB), .MIN_ON_CYCLES(MIN_ON),
      .MAX_ON_CYCLES(MAX_ON), .GAP_CYCLES(GAP), .CNT_W(11)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .low_water_level(low_water_level), .mid_water_level(mid_water_level),
      .high_water_level(high_water_level), .earth_humidity(earth_humidity),
      .air_humidity(air_humidity), .low_temperature(low_temperature),
      .alarm_clear(alarm_clear), .water_supply_valvule(water_supply_valvule),
      .alarm(alarm), .splinker_bomb(splinker_bomb),
      .dripper_valvule(dripper_valvule), .active_zone(active_zone)
   );

   always #5 clk = ~clk;

   typedef struct {
      int zone;
      bit drip;
      int len;
   } exp_t;

   exp_t exp_q[$];
   int   asserts = 0;
   int   errors  = 0;
   bit   mon_en  = 1'b1;

   // reference model state: round-robin pointer and the mid level the next grant will see
   int   mptr = 0;
   bit   cur_mid = 1'b1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      asserts++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // monitor: per-cycle exclusivity, run/gap lengths, grant transactions popped against the scoreboard
   bit       prev_on = 1'b0;
   bit       have_prev = 1'b0;
   int       run_len = 0;
   int       gap_len = 0;
   logic [2*N-1:0] cur_bits;
   always @(negedge clk) begin
      if (mon_en && rst_n) begin
         logic [2*N-1:0] bits;
         bit on;
         int z;
         exp_t e;
         bits = {dripper_valvule, splinker_bomb};
         on = |bits;
         check("exclusive", ($countones(bits) <= 1), 1);
         if (on) begin
            z = 0;
            for (int i = 0; i < N; i++) if (bits[i] | bits[N+i]) z = i;
            check("active_zone", active_zone, z);
            if (!prev_on) begin
               if (have_prev) check("gap_len", gap_len, GAP + 2);
               run_len  = 1;
               cur_bits = bits;
            end else begin
               run_len++;
               check("grant_held", (bits == cur_bits), 1);
            end
         end else begin
            check("idle_zone", active_zone, 0);
            if (prev_on) begin
               z = 0;
               for (int i = 0; i < N; i++) if (cur_bits[i] | cur_bits[N+i]) z = i;
               if (exp_q.size() == 0) begin
                  check("unexpected_grant", z, 99);
               end else begin
                  e = exp_q.pop_front();
                  check("grant_zone", z, e.zone);
                  check("grant_drip", (|cur_bits[2*N-1:N]), e.drip);
                  check("grant_len", run_len, e.len);
               end
               gap_len   = 1;
               have_prev = 1'b1;
            end else begin
               gap_len++;
            end
         end
         prev_on = on;
      end
   end

   function automatic bit outputs_on();
      return (|splinker_bomb) | (|dripper_valvule);
   endfunction

   // one grant: apply conditions in the gap, predict the grant, optionally wet the zone j0 cycles into the run
   task automatic run_grant(input logic [N-1:0] pat, input bit air, input bit temp, input int j0, input bit vary);
      exp_t e;
      int   z;
      int   waited;
      bit   nm, nh;
      earth_humidity  = pat;
      air_humidity    = air;
      low_temperature = temp;
      z = -1;
      for (int k = 0; k < N; k++) if (z < 0 && !pat[(mptr + k) % N]) z = (mptr + k) % N;
      e.zone = z;
      e.drip = air | temp | ~cur_mid;
      // the wet flag needs two synchroniser flops plus the decision cycle before the run can end
      if (j0 < 0) e.len = MAX_ON;
      else e.len = (j0 + 3 > MIN_ON) ? j0 + 3 : MIN_ON;
      if (e.len > MAX_ON) e.len = MAX_ON;
      exp_q.push_back(e);
      mptr = (z + 1) % N;
      waited = 0;
      while (!outputs_on() && waited < 100) begin
         @(negedge clk);
         waited++;
      end
      if (!outputs_on()) begin
         check("grant_timeout", 0, 1);
         return;
      end
      if (vary) begin
         nm = ($urandom_range(0, 3) != 0);
         nh = nm & 1'($urandom_range(0, 1));
         mid_water_level  = nm;
         high_water_level = nh;
         cur_mid = nm;
      end
      if (j0 >= 0) begin
         wait_cycles(j0);
         earth_humidity[z] = 1'b1;
      end
      waited = 0;
      while (outputs_on() && waited < MAX_ON + 20) begin
         @(negedge clk);
         waited++;
      end
      if (outputs_on()) check("run_timeout", 0, 1);
   endtask

   initial begin
      // reset state
      wait_cycles(2);
      check("rst_valve", water_supply_valvule, 0);
      check("rst_alarm", alarm, 0);
      check("rst_sprk", splinker_bomb, 0);
      check("rst_drip", dripper_valvule, 0);
      check("rst_zone", active_zone, 0);
      rst_n = 1'b1;

      // tank fill hysteresis
      wait_cycles(DEB + 4);
      check("valve_empty", water_supply_valvule, 1);
      check("alarm_empty", alarm, 0);
      low_water_level = 1'b1;
      wait_cycles(DEB + 4);
      check("valve_low", water_supply_valvule, 1);
      mid_water_level = 1'b1;
      wait_cycles(DEB + 4);
      check("valve_mid", water_supply_valvule, 1);
      high_water_level = 1'b1;
      wait_cycles(DEB + 4);
      check("valve_high", water_supply_valvule, 0);

      // short glitch on mid must not reach the debounced level
      mid_water_level = 1'b0;
      wait_cycles(DEB - 6);
      mid_water_level = 1'b1;
      wait_cycles(DEB + 4);
      check("glitch_alarm", alarm, 0);

      // fault high & !mid
      mid_water_level = 1'b0;
      wait_cycles(DEB + 4);
      check("fault_alarm", alarm, 1);
      check("fault_valve", water_supply_valvule, 0);
      alarm_clear = 1'b1;
      wait_cycles(1);
      alarm_clear = 1'b0;
      wait_cycles(2);
      check("clear_ignored", alarm, 1);
      mid_water_level = 1'b1;
      wait_cycles(DEB + 4);
      check("alarm_latched", alarm, 1);
      alarm_clear = 1'b1;
      wait_cycles(1);
      alarm_clear = 1'b0;
      check("alarm_cleared", alarm, 0);
      high_water_level = 1'b0;
      wait_cycles(DEB + 4);
      check("valve_hold_closed", water_supply_valvule, 0);
      high_water_level = 1'b1;
      wait_cycles(DEB + 4);

      // directed grants: full-length sprinkler, next zone, dripper ended early by wetness
      run_grant(4'b0000, 0, 0, -1, 0);
      run_grant(4'b0000, 0, 0, 0, 0);
      run_grant(4'b1011, 0, 1, 10, 0);
      // three rounds with every zone dry
      for (int i = 0; i < 3 * N; i++) run_grant(4'b0000, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0, 0);
      // randomized grants
      for (int i = 0; i < 30; i++) begin
         logic [N-1:0] pat;
         int j0;
         pat = N'($urandom);
         if (pat == '1) pat[$urandom_range(0, N - 1)] = 1'b0;
         j0 = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, 90));
         run_grant(pat, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), j0, 1);
      end
      wait_cycles(3);
      check("scoreboard_empty", exp_q.size(), 0);

      // asynchronous reset in the middle of a run
      mon_en = 1'b0;
      earth_humidity = '0;
      begin
         int waited;
         waited = 0;
         while (!outputs_on() && waited < 100) begin
            @(negedge clk);
            waited++;
         end
      end
      check("pre_reset_on", outputs_on(), 1);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_sprk", splinker_bomb, 0);
      check("async_rst_drip", dripper_valvule, 0);
      check("async_rst_zone", active_zone, 0);
      check("async_rst_alarm", alarm, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", asserts, errors);
      $finish;
   end

endmodule
